mor1kx_pic_multimode: RTL
=========================

# mor1kx_pic_multimode

Parametrised programmable interrupt controller for the mor1kx CPU, sitting in SPR group 9 between the external interrupt lines and the exception unit. Each line is individually selectable as level-sensitive or true rising-edge-sensitive at run time through a new trigger-mode SPR. An optional input synchroniser and the line count are set by parameters. A registered-status priority encoder gives the exception unit the lowest-numbered pending line, so software need not scan PICSR.

## Interface
- OPTION_PIC_LINES, 32: implemented lines, 2..32; bits at and above this index are not implemented.
- OPTION_PIC_NMI_LINES, 2: lowest lines that are permanently unmasked, 0..OPTION_PIC_LINES.
- OPTION_PIC_SYNC_STAGES, 2: flops in the irq_i synchroniser, 0..3; 0 means irq_i is used directly.
- OPTION_PIC_TRIGGER_RESET, 32'h0: reset value of PICTR; bit=1 means edge.
- clk  in  1  clock; the whole block runs on this single clock.
- rst  in  1  reset; synchronous and active-high.
- irq_i  in  32  raw interrupt lines.
- spr_we_i  in  1  SPR write strobe.
- spr_addr_i  in  16  SPR address.
- spr_dat_i  in  32  SPR write data.
- spr_bus_ack  out  1  tied to 1.
- spr_dat_o  out  32  SPR read data (combinational).
- spr_picmr_o  out  32  mask register.
- spr_picsr_o  out  32  status register.
- spr_pictr_o  out  32  trigger-mode register.
- pic_irq_o  out  1  OR of spr_picsr_o.
- pic_id_o  out  5  index of the lowest set PICSR bit; 0 when none is set.

## Operation
- **Synchroniser.** irq_s is irq_i delayed by OPTION_PIC_SYNC_STAGES flops. irq_p is irq_s delayed by one more flop and is used for edge detection. Both reset to 0.
- **Masking.** unmasked = PICMR & irq_s. Rising edge for line n = irq_s[n] & ~irq_p[n] & PICMR[n].
- **PICMR write** (OR1K_SPR_PICMR_ADDR): loads spr_dat_i. The NMI bits are forced to 1 and the unimplemented bits are forced to 0. Reset value is the NMI bits set to 1, all other bits 0.
- **PICTR write** (OR1K_SPR_PICTR_ADDR): loads spr_dat_i. Unimplemented bits are forced to 0. Reset value is OPTION_PIC_TRIGGER_RESET masked to the implemented lines.
- **PICSR next value, level line:** PICSR[n] = unmasked[n]. Writes to PICSR are ignored for level lines.
- **PICSR next value, edge line:**
  - The bit sets on a rising edge.
  - The bit clears when PICSR is written with spr_dat_i[n]=1.
  - If a rising edge and the clear occur in the same cycle, set wins so no edge is lost.
  - Otherwise the bit holds.
- **Mode change:** on a PICTR write, every PICSR bit whose mode bit changes is cleared in that same cycle. From the next cycle the bit follows the new mode.
- **Unimplemented lines:** PICSR bits at and above OPTION_PIC_LINES are always 0.
- **Reset:** PICSR is 0, pic_irq_o is 0, pic_id_o is 0, and all synchroniser flops are 0.
- **SPR read:**
  - PICMR, PICSR and PICTR addresses return the corresponding register.
  - Any other address returns 0.
  - spr_bus_ack is always 1.
- **Priority encoder:** purely combinational from the PICSR register. It selects the lowest index.

## Timing
- **Level line latency:** a change on irq_i appears in PICSR after OPTION_PIC_SYNC_STAGES+1 rising clock edges.
- **Edge line latency:** the same latency applies. A pulse on irq_s one cycle wide is captured.
- pic_irq_o and pic_id_o change in the same cycle as PICSR; they add no extra latency.
- An SPR write takes effect at the next clock edge. A read in the same cycle returns the old value.
- A PICMR write that masks a line:
  - a level bit drops one cycle later;
  - a latched edge bit stays set until software clears it.
- rst asserted mid-operation overrides every write and every edge in that cycle.

## Structure
- Add OR1K_SPR_PICTR_ADDR (16'h4803) to mor1kx-defines.v alongside the existing PICMR and PICSR defines. No other shared constants are needed.
- One sub-module is used: mor1kx_pic_prio_enc, a parametrised lowest-set-bit encoder (width in, 5-bit index out, valid out).
- The synchroniser and the per-line status logic are generate loops inside this block.

## Test plan
- **Reset:** with defaults, after reset PICMR=32'h3, PICSR=0 and PICTR=0. Writing PICMR=32'h0 reads back 32'h3.
- **Level line:** PICMR=32'h10, hold irq_i[4]=1. PICSR[4]=1 exactly 3 cycles later (SYNC_STAGES=2) and pic_id_o=4. Dropping irq_i[4] clears the bit 3 cycles later.
- **Edge line:** PICTR=32'h100, PICMR=32'h100, pulse irq_i[8] for 1 cycle. PICSR[8] sets and stays set. Writing PICSR=32'h100 clears it; writing PICSR=0 does not.
- **Clear/edge collision:** write PICSR=32'h100 in the same cycle as a new rising edge on line 8 arrives at irq_s. PICSR[8] stays 1.
- **Priority and unimplemented lines:** set lines 3, 7 and 20 pending. pic_id_o=3; clear line 3 and pic_id_o=7. With OPTION_PIC_LINES=16, irq_i[20] never sets PICSR and a PICMR write of 32'hFFFFFFFF reads back 32'h0000FFFF.
- **Mode change:** edge line 8 latched, then write PICTR=0. PICSR[8]=0 next cycle, then PICSR[8] follows the level of irq_i[8].

Source files
------------

// File: rtl/mor1kx_pic_multimode_pkg.sv
// Shared SPR addresses, register-select decode and mask helpers for the
// multimode programmable interrupt controller.
package mor1kx_pic_multimode_pkg;

    localparam logic [15:0] OR1K_SPR_PICMR_ADDR = 16'h4800;
    localparam logic [15:0] OR1K_SPR_PICSR_ADDR = 16'h4802;
    localparam logic [15:0] OR1K_SPR_PICTR_ADDR = 16'h4803;

    typedef enum logic [1:0] {
        SPR_SEL_NONE  = 2'd0,
        SPR_SEL_PICMR = 2'd1,
        SPR_SEL_PICSR = 2'd2,
        SPR_SEL_PICTR = 2'd3
    } spr_sel_e;

    function automatic spr_sel_e spr_decode(input logic [15:0] addr);
        spr_sel_e sel;
        case (addr)
            OR1K_SPR_PICMR_ADDR: sel = SPR_SEL_PICMR;
            OR1K_SPR_PICSR_ADDR: sel = SPR_SEL_PICSR;
            OR1K_SPR_PICTR_ADDR: sel = SPR_SEL_PICTR;
            default:             sel = SPR_SEL_NONE;
        endcase
        return sel;
    endfunction

    // Vector with the n lowest bits set; n may be anywhere in 0..32.
    function automatic logic [31:0] low_mask(input int n);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/mor1kx_pic_multimode_if.sv
// SPR bus between the CPU SPR decoder (master) and the PIC (slave).
interface mor1kx_pic_multimode_if;
    logic        spr_we_i;
    logic [15:0] spr_addr_i;
    logic [31:0] spr_dat_i;
    logic        spr_bus_ack;
    logic [31:0] spr_dat_o;

    modport master (
        output spr_we_i, spr_addr_i, spr_dat_i,
        input  spr_bus_ack, spr_dat_o
    );

    modport slave (
        input  spr_we_i, spr_addr_i, spr_dat_i,
        output spr_bus_ack, spr_dat_o
    );
endinterface

// File: rtl/mor1kx_pic_prio_enc.sv
// Lowest-set-bit encoder: idx is the lowest set bit of req, 0 when none is set.
module mor1kx_pic_prio_enc #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] req,
    output logic [4:0]       idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last one to win.
    always_comb begin
        idx   = 5'd0;
        valid = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            idx   = req[i] ? 5'(i) : idx;
            valid = valid | req[i];
        end
    end

endmodule

// File: rtl/mor1kx_pic_multimode.sv
// Programmable interrupt controller (SPR group 9) with per-line level/edge
// trigger selection, optional input synchroniser and lowest-line encoder.
module mor1kx_pic_multimode
    import mor1kx_pic_multimode_pkg::*;
#(
    parameter int          OPTION_PIC_LINES         = 32,
    parameter int          OPTION_PIC_NMI_LINES     = 2,
    parameter int          OPTION_PIC_SYNC_STAGES   = 2,
    parameter logic [31:0] OPTION_PIC_TRIGGER_RESET = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            irq_i,
    mor1kx_pic_multimode_if.slave  spr,
    output logic [31:0]            spr_picmr_o,
    output logic [31:0]            spr_picsr_o,
    output logic [31:0]            spr_pictr_o,
    output logic                   pic_irq_o,
    output logic [4:0]             pic_id_o
);

    localparam logic [31:0] IMPL_MASK = low_mask(OPTION_PIC_LINES);
    localparam logic [31:0] NMI_MASK  = low_mask(OPTION_PIC_NMI_LINES) & IMPL_MASK;

    logic [31:0] irq_sync_s;
    logic [31:0] irq_prev_r;
    logic [31:0] picmr_r;
    logic [31:0] picsr_r;
    logic [31:0] pictr_r;
    logic [31:0] picsr_nxt_s;
    logic [31:0] pictr_nxt_s;
    logic [31:0] mode_chg_s;
    logic [31:0] unmasked_s;
    logic [31:0] rise_s;
    logic [31:0] rdata_s;
    logic        picmr_we_s;
    logic        picsr_we_s;
    logic        pictr_we_s;
    logic        prio_valid_s;
    spr_sel_e    sel_s;

    generate
        if (OPTION_PIC_SYNC_STAGES == 0) begin : g_nosync
            assign irq_sync_s = irq_i;
        end else begin : g_sync
            logic [31:0] stage_r [OPTION_PIC_SYNC_STAGES];

            // Shift chain bringing the raw lines into the clock domain.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < OPTION_PIC_SYNC_STAGES; i++) begin
                        stage_r[i] <= 32'h0;
                    end
                end else begin
                    stage_r[0] <= irq_i;
                    for (int i = 1; i < OPTION_PIC_SYNC_STAGES; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign irq_sync_s = stage_r[OPTION_PIC_SYNC_STAGES-1];
        end
    endgenerate

    assign sel_s       = spr_decode(spr.spr_addr_i);
    assign picmr_we_s  = spr.spr_we_i & (sel_s == SPR_SEL_PICMR);
    assign picsr_we_s  = spr.spr_we_i & (sel_s == SPR_SEL_PICSR);
    assign pictr_we_s  = spr.spr_we_i & (sel_s == SPR_SEL_PICTR);
    assign pictr_nxt_s = spr.spr_dat_i & IMPL_MASK;
    assign mode_chg_s  = pictr_we_s ? (pictr_nxt_s ^ pictr_r) : 32'h0;
    assign unmasked_s  = picmr_r & irq_sync_s;
    assign rise_s      = irq_sync_s & ~irq_prev_r & picmr_r;

    // Edge lines: a new rise beats a software clear in the same cycle.
    generate
        for (genvar n = 0; n < 32; n++) begin : g_line
            if (n < OPTION_PIC_LINES) begin : g_impl
                assign picsr_nxt_s[n] = mode_chg_s[n] ? 1'b0 :
                                        pictr_r[n]    ? (rise_s[n] | (picsr_r[n] &
                                                         ~(picsr_we_s & spr.spr_dat_i[n]))) :
                                                        unmasked_s[n];
            end else begin : g_unimpl
                assign picsr_nxt_s[n] = 1'b0;
            end
        end
    endgenerate

    // Architectural registers and the edge-detect history flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            picmr_r    <= NMI_MASK;
            pictr_r    <= OPTION_PIC_TRIGGER_RESET & IMPL_MASK;
            picsr_r    <= 32'h0;
            irq_prev_r <= 32'h0;
        end else begin
            if (picmr_we_s) begin
                picmr_r <= (spr.spr_dat_i | NMI_MASK) & IMPL_MASK;
            end
            if (pictr_we_s) begin
                pictr_r <= pictr_nxt_s;
            end
            picsr_r    <= picsr_nxt_s;
            irq_prev_r <= irq_sync_s;
        end
    end

    // SPR read mux.
    always_comb begin
        rdata_s = 32'h0;
        case (sel_s)
            SPR_SEL_PICMR: rdata_s = picmr_r;
            SPR_SEL_PICSR: rdata_s = picsr_r;
            SPR_SEL_PICTR: rdata_s = pictr_r;
            default:       rdata_s = 32'h0;
        endcase
    end

    mor1kx_pic_prio_enc #(.WIDTH(32)) u_prio_enc (
        .req   (picsr_r),
        .idx   (pic_id_o),
        .valid (prio_valid_s)
    );

    assign spr.spr_dat_o   = rdata_s;
    assign spr.spr_bus_ack = 1'b1;
    assign spr_picmr_o     = picmr_r;
    assign spr_picsr_o     = picsr_r;
    assign spr_pictr_o     = pictr_r;
    assign pic_irq_o       = prio_valid_s;

endmodule
